fifo_read_ctrl: RTL and testbench
=================================

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload width in bits.
REQ-002 SHALL have parameter PTR_WIDTH, default 4, meaning address bits; depth = 2**PTR_WIDTH, pointers carry one extra wrap bit.
REQ-003 SHALL have port r_clk  input  1  read-domain clock; sole clock of the block.
REQ-004 SHALL have port rreset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all unread entries.
REQ-006 SHALL have port write_ptr_gray  input  PTR_WIDTH+1  Gray-coded write pointer, asynchronous to r_clk.
REQ-007 SHALL have port mem_rd_addr  output  PTR_WIDTH  storage read address, equal to read pointer low bits.
REQ-008 SHALL have port mem_rd_data  input  DATA_WIDTH  storage data at mem_rd_addr, combinational same cycle.
REQ-009 SHALL have port m_valid  output  1  output word available.
REQ-010 SHALL have port m_ready  input  1  consumer accepts word.
REQ-011 SHALL have port m_data  output  DATA_WIDTH  output word.
REQ-012 SHALL have port empty  output  1  storage holds no unread entries (output register excluded).
REQ-013 SHALL have port read_ptr_gray  output  PTR_WIDTH+1  registered Gray read pointer for the write domain.
REQ-014 SHALL have port rd_level  output  PTR_WIDTH+1  entries in storage not yet fetched.

Function
REQ-015 SHALL synchronise write_ptr_gray through two r_clk flops, then convert Gray to binary (wsync_bin).
REQ-016 SHALL hold binary read pointer rptr_bin, PTR_WIDTH+1 bits, modulo 2**(PTR_WIDTH+1) increment.
REQ-017 SHALL drive empty combinationally = (rptr_bin == wsync_bin).
REQ-018 SHALL drive rd_level combinationally = (wsync_bin - rptr_bin) mod 2**(PTR_WIDTH+1); range 0..2**PTR_WIDTH.
REQ-019 SHALL drive read_ptr_gray from a flop loaded each cycle with bin2gray of next rptr_bin, so it changes glitch-free, one bit per increment.
REQ-020 SHALL implement output stage FSM, states OUT_EMPTY (m_valid=0) and OUT_VALID (m_valid=1); m_valid is a flop output.
REQ-021 SHALL fetch (load m_data from mem_rd_data, increment rptr_bin) when !empty and (state==OUT_EMPTY or m_ready) and !flush.
REQ-022 SHALL transition OUT_EMPTY->OUT_VALID on fetch; OUT_VALID->OUT_EMPTY on m_ready with no fetch; OUT_VALID stays on m_ready with fetch (back-to-back, one word per cycle).
REQ-023 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-024 SHALL, for a write_ptr_gray change settled before r_clk edge E, set empty=0 after edge E+1 and m_valid=1 after edge E+2 if OUT_EMPTY.
REQ-025 SHALL, on flush, load rptr_bin with wsync_bin and go to OUT_EMPTY; flush overrides fetch and m_ready in that cycle.
REQ-026 SHALL ignore m_ready while m_valid=0.
REQ-027 SHALL sustain wrap-around: rptr_bin 2**(PTR_WIDTH+1)-1 -> 0, mem_rd_addr 2**PTR_WIDTH-1 -> 0, no bubble.

Reset
REQ-028 SHALL, on rreset=1, asynchronously clear sync flops, rptr_bin, read_ptr_gray, m_data to 0 and state to OUT_EMPTY.
REQ-029 SHALL present after reset: m_valid=0, empty=1, rd_level=0, mem_rd_addr=0, read_ptr_gray=0.
REQ-030 SHALL, on reset mid-transfer, drop the held word without handshake; first post-reset fetch reads address 0.

Structure
REQ-031 SHALL take gray2bin/bin2gray functions and pointer-width localparams from shared package fifo_pkg, also used by fifo_write.
REQ-032 SHALL instantiate sub-module ptr_sync (parameterised-width two-flop synchroniser, async active-high reset).

Verification
REQ-033 SHALL check reset: assert rreset mid-stream with m_valid=1 -> next cycle m_valid=0, empty=1, read_ptr_gray=0.
REQ-034 SHALL check latency: write_ptr_gray 0->1, m_ready=0 -> empty=0 after 2nd edge, m_valid=1 and m_data=mem[0] after 3rd, held 10 cycles.
REQ-035 SHALL check streaming: 16 words preloaded, m_ready=1 -> 16 consecutive m_valid cycles, data mem[0..15], then m_valid=0, empty=1, read_ptr_gray=bin2gray(16).
REQ-036 SHALL check wrap: 40 words through depth 16 with random m_ready -> in-order data, rptr_bin wraps 31->0, no loss or duplication.
REQ-037 SHALL check flush: rd_level=5, m_valid=1, assert flush with m_ready=1 -> next cycle m_valid=0, rd_level=0, empty=1, no extra fetch.
REQ-038 SHALL check full level: write_ptr_gray=bin2gray(16), rptr_bin=0 -> rd_level=16; one fetch -> rd_level=15.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer-width defaults, output-stage states and Gray/binary helpers for the FIFO read and write sides
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int PTR_WIDTH_DEF = 4;
  localparam int PTR_MAX = 32;
  typedef enum logic {OUT_EMPTY, OUT_VALID} out_state_t;
  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b = g;
    for (int i = 1; i < PTR_MAX; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/ptr_sync.sv
// ptr_sync: two-flop synchroniser (clk, rst async active-high, d in, q out)
module ptr_sync #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: async-FIFO read side (synced write pointer, read pointer, Gray pointer out, level, valid/ready output register)
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PTR_WIDTH  = PTR_WIDTH_DEF
) (
  input  logic                  r_clk,
  input  logic                  rreset,
  input  logic                  flush,
  input  logic [PTR_WIDTH:0]    write_ptr_gray,
  output logic [PTR_WIDTH-1:0]  mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  empty,
  output logic [PTR_WIDTH:0]    read_ptr_gray,
  output logic [PTR_WIDTH:0]    rd_level
);
  localparam int PW = PTR_WIDTH + 1;
  logic [PW-1:0] wsync_gray, wsync_bin, rptr_bin, rptr_next;
  out_state_t state, state_next;
  logic fetch;
  ptr_sync #(.WIDTH(PW)) u_sync (
    .clk(r_clk),
    .rst(rreset),
    .d(write_ptr_gray),
    .q(wsync_gray)
  );
  assign wsync_bin = PW'(gray2bin(PTR_MAX'(wsync_gray)));
  assign empty = rptr_bin == wsync_bin;
  assign rd_level = wsync_bin - rptr_bin;
  assign mem_rd_addr = rptr_bin[PTR_WIDTH-1:0];
  assign m_valid = state == OUT_VALID;
  assign fetch = !empty && (!m_valid || m_ready) && !flush;
  always_comb begin
    rptr_next = flush ? wsync_bin : rptr_bin + PW'(fetch);
    state_next = flush ? OUT_EMPTY : fetch ? OUT_VALID : m_ready ? OUT_EMPTY : state;
  end
  always_ff @(posedge r_clk or posedge rreset)
    if (rreset) begin
      state <= OUT_EMPTY;
      rptr_bin <= '0;
      read_ptr_gray <= '0;
      m_data <= '0;
    end else begin
      state <= state_next;
      rptr_bin <= rptr_next;
      read_ptr_gray <= PW'(bin2gray(PTR_MAX'(rptr_next)));
      if (fetch) m_data <= mem_rd_data;
    end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: directed self-checking bench for fifo_read_ctrl
module tb_fifo_read_ctrl;
  logic r_clk = 0, rreset = 1, flush = 0, m_ready = 0;
  logic [4:0] wptr = 0;
  logic [4:0] write_ptr_gray, read_ptr_gray, rd_level;
  logic [3:0] mem_rd_addr;
  logic [7:0] mem_rd_data, m_data;
  logic m_valid, empty;
  logic [7:0] mem [16];
  int total = 0, bad = 0, wr_cnt, rd_cnt, cyc;
  always #5 r_clk = ~r_clk;
  assign write_ptr_gray = wptr ^ (wptr >> 1);
  assign mem_rd_data = mem[mem_rd_addr];
  fifo_read_ctrl #(.DATA_WIDTH(8), .PTR_WIDTH(4)) dut (
    .r_clk(r_clk),
    .rreset(rreset),
    .flush(flush),
    .write_ptr_gray(write_ptr_gray),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .empty(empty),
    .read_ptr_gray(read_ptr_gray),
    .rd_level(rd_level)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
    repeat (2) @(negedge r_clk);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_level", 32'(rd_level), 0);
    chk("rst_addr", 32'(mem_rd_addr), 0);
    chk("rst_rpg", 32'(read_ptr_gray), 0);
    rreset = 0;
    @(negedge r_clk);
    wptr = 1;
    @(negedge r_clk);
    chk("lat_e1_empty", 32'(empty), 1);
    @(negedge r_clk);
    chk("lat_e2_empty", 32'(empty), 0);
    chk("lat_e2_valid", 32'(m_valid), 0);
    @(negedge r_clk);
    chk("lat_e3_valid", 32'(m_valid), 1);
    chk("lat_e3_data", 32'(m_data), 32'hA0);
    chk("lat_e3_level", 32'(rd_level), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge r_clk);
      chk("hold_valid", 32'(m_valid), 1);
      chk("hold_data", 32'(m_data), 32'hA0);
    end
    rreset = 1;
    wptr = 0;
    @(negedge r_clk);
    chk("rst2_valid", 32'(m_valid), 0);
    chk("rst2_empty", 32'(empty), 1);
    chk("rst2_rpg", 32'(read_ptr_gray), 0);
    rreset = 0;
    @(negedge r_clk);
    for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i * 3);
    wptr = 16;
    @(negedge r_clk);
    chk("lvl_e1", 32'(rd_level), 0);
    @(negedge r_clk);
    chk("lvl_full", 32'(rd_level), 16);
    chk("lvl_full_empty", 32'(empty), 0);
    chk("lvl_full_valid", 32'(m_valid), 0);
    @(negedge r_clk);
    chk("lvl_after_fetch", 32'(rd_level), 15);
    chk("stream_valid0", 32'(m_valid), 1);
    chk("stream_data0", 32'(m_data), 32'h30);
    m_ready = 1;
    for (int k = 1; k < 16; k++) begin
      @(negedge r_clk);
      chk("stream_valid", 32'(m_valid), 1);
      chk("stream_data", 32'(m_data), 32'(8'h30 + 8'(k * 3)));
    end
    @(negedge r_clk);
    chk("stream_end_valid", 32'(m_valid), 0);
    chk("stream_end_empty", 32'(empty), 1);
    chk("stream_end_rpg", 32'(read_ptr_gray), 24);
    chk("stream_end_level", 32'(rd_level), 0);
    m_ready = 0;
    wr_cnt = 0;
    rd_cnt = 0;
    cyc = 0;
    while (rd_cnt < 40 && cyc < 2000) begin
      @(negedge r_clk);
      cyc++;
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid && m_ready) begin
        chk("wrap_data", 32'(m_data), 32'(8'(rd_cnt) ^ 8'h5A));
        rd_cnt++;
      end
      if (wr_cnt < 40 && wr_cnt - rd_cnt < 16) begin
        mem[wptr[3:0]] = 8'(wr_cnt) ^ 8'h5A;
        wptr = wptr + 1;
        wr_cnt++;
      end
    end
    chk("wrap_count", 32'(rd_cnt), 40);
    @(negedge r_clk);
    m_ready = 0;
    repeat (2) @(negedge r_clk);
    chk("wrap_end_valid", 32'(m_valid), 0);
    chk("wrap_end_empty", 32'(empty), 1);
    chk("wrap_end_rpg", 32'(read_ptr_gray), 20);
    for (int i = 0; i < 6; i++) begin
      mem[wptr[3:0]] = 8'hC0 + 8'(i);
      wptr = wptr + 1;
    end
    repeat (3) @(negedge r_clk);
    chk("fl_pre_level", 32'(rd_level), 5);
    chk("fl_pre_valid", 32'(m_valid), 1);
    chk("fl_pre_data", 32'(m_data), 32'hC0);
    flush = 1;
    m_ready = 1;
    @(negedge r_clk);
    chk("fl_valid", 32'(m_valid), 0);
    chk("fl_level", 32'(rd_level), 0);
    chk("fl_empty", 32'(empty), 1);
    flush = 0;
    m_ready = 0;
    @(negedge r_clk);
    chk("fl_after_valid", 32'(m_valid), 0);
    chk("fl_after_rpg", 32'(read_ptr_gray), 17);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
